// File: rtl/usb_sync_pid_framer_if.sv
// Receive-side bus between the bit-unstuffer, the SYNC/PID framer and the packet decoder.
interface usb_sync_pid_framer_if;
  logic       data_valid;
  logic       data_in;
  logic       eop;
  logic       sync_detected;
  logic [3:0] pid;
  logic       pid_valid;
  logic       pid_error;
  logic       payload_bit;
  logic       payload_valid;
  logic       in_packet;

  modport master (
    output data_valid, data_in, eop,
    input  sync_detected, pid, pid_valid, pid_error,
           payload_bit, payload_valid, in_packet
  );

  modport slave (
    input  data_valid, data_in, eop,
    output sync_detected, pid, pid_valid, pid_error,
           payload_bit, payload_valid, in_packet
  );
endinterface

// File: rtl/usb_sync_pid_framer.sv
// SYNC hunter with tolerant zero-run, PID capture/check and payload forwarding.
// All outputs registered, one clk after the qualifying input.
module usb_sync_pid_framer #(
  parameter int unsigned MIN_ZEROS = 6,
  parameter bit          PID_CHECK = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  usb_sync_pid_framer_if.slave  bus
);

  localparam logic [1:0] ST_HUNT    = 2'd0;
  localparam logic [1:0] ST_PID     = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;

  logic [1:0] state;
  logic [4:0] zero_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] pid_sr;
  logic [7:0] pid_byte;
  logic       pid_ok;

  // Byte as it will look once the current bit is shifted in (LSB first).
  always_comb begin
    pid_byte = {bus.data_in, pid_sr[7:1]};
    pid_ok   = !PID_CHECK || (pid_byte[7:4] == ~pid_byte[3:0]);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state             <= ST_HUNT;
      zero_cnt          <= '0;
      bit_cnt           <= '0;
      pid_sr            <= '0;
      bus.sync_detected <= 1'b0;
      bus.pid           <= '0;
      bus.pid_valid     <= 1'b0;
      bus.pid_error     <= 1'b0;
      bus.payload_bit   <= 1'b0;
      bus.payload_valid <= 1'b0;
      bus.in_packet     <= 1'b0;
    end else begin
      bus.sync_detected <= 1'b0;
      bus.pid_valid     <= 1'b0;
      bus.pid_error     <= 1'b0;
      bus.payload_valid <= 1'b0;

      // eop takes priority over a coincident valid bit, which is dropped.
      if (bus.eop) begin
        if (state == ST_PID) bus.pid_error <= 1'b1;
        state         <= ST_HUNT;
        zero_cnt      <= '0;
        bit_cnt       <= '0;
        bus.in_packet <= 1'b0;
      end else if (bus.data_valid) begin
        case (state)
          ST_HUNT: begin
            if (!bus.data_in) begin
              if (zero_cnt != 5'd31) zero_cnt <= zero_cnt + 5'd1;
            end else begin
              zero_cnt <= '0;
              if (zero_cnt >= 5'(MIN_ZEROS)) begin
                bus.sync_detected <= 1'b1;
                bus.in_packet     <= 1'b1;
                bit_cnt           <= '0;
                state             <= ST_PID;
              end
            end
          end
          ST_PID: begin
            pid_sr  <= pid_byte;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (pid_ok) begin
                bus.pid       <= pid_byte[3:0];
                bus.pid_valid <= 1'b1;
                state         <= ST_PAYLOAD;
              end else begin
                bus.pid_error <= 1'b1;
                bus.in_packet <= 1'b0;
                zero_cnt      <= '0;
                state         <= ST_HUNT;
              end
            end
          end
          ST_PAYLOAD: begin
            bus.payload_bit   <= bus.data_in;
            bus.payload_valid <= 1'b1;
          end
          default: state <= ST_HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_sync_pid_framer.sv
// Randomised bench: two framers (PID check on/off) fed the same stream, compared every cycle to a packet-level model.
module tb_usb_sync_pid_framer;
  localparam int MIN_Z = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic dv = 1'b0, di = 1'b0, ep = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   plv_cnt = 0;

  always #5 clk = ~clk;

  usb_sync_pid_framer_if bus0 ();
  usb_sync_pid_framer_if bus1 ();
  assign bus0.data_valid = dv;
  assign bus0.data_in    = di;
  assign bus0.eop        = ep;
  assign bus1.data_valid = dv;
  assign bus1.data_in    = di;
  assign bus1.eop        = ep;

  usb_sync_pid_framer #(.MIN_ZEROS(MIN_Z), .PID_CHECK(1'b1)) u0 (.clk(clk), .rst(rst), .bus(bus0));
  usb_sync_pid_framer #(.MIN_ZEROS(MIN_Z), .PID_CHECK(1'b0)) u1 (.clk(clk), .rst(rst), .bus(bus1));

  // Model: packet phase (0 hunting, 1 collecting PID, 2 payload), zero-run length, collected PID bits.
  int         m_phase [2];
  int         m_run   [2];
  int         m_nbits [2];
  logic [7:0] m_byte  [2];
  logic       e_sync [2], e_pidv [2], e_pide [2], e_pl [2], e_plv [2], e_inp [2];
  logic [3:0] e_pid  [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_phase[k] = 0; m_run[k] = 0; m_nbits[k] = 0; m_byte[k] = '0;
      e_sync[k] = 0; e_pidv[k] = 0; e_pide[k] = 0; e_pl[k] = 0; e_plv[k] = 0;
      e_inp[k] = 0; e_pid[k] = '0;
    end
  endtask

  task automatic model_step(input int k, input bit v, input bit d, input bit e, input bit chk);
    bit ok;
    e_sync[k] = 0; e_pidv[k] = 0; e_pide[k] = 0; e_plv[k] = 0;
    if (e) begin
      if (m_phase[k] == 1) e_pide[k] = 1;
      m_phase[k] = 0; m_run[k] = 0; m_nbits[k] = 0; e_inp[k] = 0;
    end else if (v) begin
      if (m_phase[k] == 0) begin
        if (!d) m_run[k]++;
        else begin
          if (m_run[k] >= MIN_Z) begin
            e_sync[k] = 1; e_inp[k] = 1; m_phase[k] = 1; m_nbits[k] = 0; m_byte[k] = '0;
          end
          m_run[k] = 0;
        end
      end else if (m_phase[k] == 1) begin
        m_byte[k] = m_byte[k] | (8'(d) << m_nbits[k]);
        m_nbits[k]++;
        if (m_nbits[k] == 8) begin
          ok = !chk || (m_byte[k][7:4] == ~m_byte[k][3:0]);
          if (ok) begin
            e_pid[k] = m_byte[k][3:0]; e_pidv[k] = 1; m_phase[k] = 2;
          end else begin
            e_pide[k] = 1; e_inp[k] = 0; m_phase[k] = 0; m_run[k] = 0;
          end
        end
      end else begin
        e_pl[k] = d; e_plv[k] = 1;
      end
    end
  endtask

  task automatic cmp_inst(input int k, input logic s, input logic [3:0] p, input logic pv,
                          input logic pe, input logic pb, input logic plv, input logic inp);
    check($sformatf("u%0d_sync_detected", k), 32'(s),   32'(e_sync[k]));
    check($sformatf("u%0d_pid", k),           32'(p),   32'(e_pid[k]));
    check($sformatf("u%0d_pid_valid", k),     32'(pv),  32'(e_pidv[k]));
    check($sformatf("u%0d_pid_error", k),     32'(pe),  32'(e_pide[k]));
    check($sformatf("u%0d_payload_bit", k),   32'(pb),  32'(e_pl[k]));
    check($sformatf("u%0d_payload_valid", k), 32'(plv), 32'(e_plv[k]));
    check($sformatf("u%0d_in_packet", k),     32'(inp), 32'(e_inp[k]));
  endtask

  // One clock: drive at negedge, model at posedge, sample 1 time unit later.
  task automatic step(input bit v, input bit d, input bit e);
    dv = v; di = d; ep = e;
    @(posedge clk);
    if (!rst) model_reset();
    else begin
      model_step(0, v, d, e, 1'b1);
      model_step(1, v, d, e, 1'b0);
    end
    #1;
    cmp_inst(0, bus0.sync_detected, bus0.pid, bus0.pid_valid, bus0.pid_error,
             bus0.payload_bit, bus0.payload_valid, bus0.in_packet);
    cmp_inst(1, bus1.sync_detected, bus1.pid, bus1.pid_valid, bus1.pid_error,
             bus1.payload_bit, bus1.payload_valid, bus1.in_packet);
    if (bus0.payload_valid) plv_cnt++;
    @(negedge clk);
  endtask

  task automatic send_bit(input bit b, input int max_gap);
    repeat ($urandom_range(max_gap, 0)) step(1'b0, 1'($urandom), 1'b0);
    step(1'b1, b, 1'b0);
  endtask

  task automatic send_sync(input int nz, input int max_gap);
    repeat (nz) send_bit(1'b0, max_gap);
    send_bit(1'b1, max_gap);
  endtask

  task automatic send_byte(input logic [7:0] b, input int n, input int max_gap);
    for (int i = 0; i < n; i++) send_bit(b[i], max_gap);
  endtask

  task automatic send_eop();
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] b;
    logic [3:0] n;
    model_reset();
    @(negedge clk);
    step(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);

    // FS SYNC and OUT PID.
    send_sync(7, 0);
    send_byte(8'hE1, 8, 0);
    step(1'b0, 1'b0, 1'b0);
    send_eop();

    // Zero-run boundary: 5 zeros rejected, 6 accepted.
    send_sync(5, 1);
    step(1'b0, 1'b0, 1'b0);
    send_sync(6, 1);
    send_eop();

    // Bad complement: error with check, accepted without.
    send_sync(7, 0);
    send_byte(8'hE2, 8, 0);
    send_byte(8'h0B, 4, 0);
    send_eop();

    // 16 payload bits with gaps.
    send_sync(6, 2);
    send_byte(8'h69, 8, 3);
    plv_cnt = 0;
    for (int i = 0; i < 16; i++) send_bit(1'($urandom), 3);
    step(1'b0, 1'b0, 1'b0);
    check("payload_count", 32'(plv_cnt), 32'd16);
    send_eop();

    // eop with a coincident valid bit after 3 PID bits, then a fresh packet.
    send_sync(7, 0);
    send_byte(8'hD2, 3, 0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    send_sync(6, 0);
    send_byte(8'hA5, 8, 0);
    send_eop();

    // Reset mid-payload, then a full packet.
    send_sync(8, 0);
    send_byte(8'hC3, 8, 0);
    send_byte(8'h5A, 5, 0);
    rst = 1'b0;
    step(1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    send_sync(6, 0);
    send_byte(8'h4B, 8, 1);
    send_byte(8'h96, 8, 1);
    send_eop();

    // Random packets: noise, variable SYNC, good/bad PIDs, truncation, payload, eop.
    for (int p = 0; p < 60; p++) begin
      repeat ($urandom_range(6, 0)) send_bit(1'($urandom), 2);
      send_sync($urandom_range(10, 1), 2);
      n = 4'($urandom);
      b = ($urandom_range(1, 0) == 1) ? {~n, n} : 8'($urandom);
      if ($urandom_range(7, 0) == 0) begin
        send_byte(b, $urandom_range(7, 0), 2);
        step(1'b1, 1'($urandom), 1'b1);
      end else begin
        send_byte(b, 8, 2);
        for (int i = 0; i < int'($urandom_range(20, 0)); i++) send_bit(1'($urandom), 2);
        step(1'($urandom), 1'($urandom), 1'b1);
      end
      step(1'b0, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
